idli_fetch_m: RTL
=================

Name: idli_fetch_m

Overview:
- Instruction fetch sequencer and shared-memory scheduler for the nibble-serial core.
- Owns the PC and the free-running 2-bit cycle counter (ctr_t).
- Arbitrates one word-per-slot memory port between instruction fetch and the LSU.
- Streams fetched instructions 4b per cycle to decode as enc/enc_vld and squashes in-flight fetches on redirect.

Parameters:
- RST_PC, 16'h0000, PC value loaded on reset.
- STARVE_MAX, 4, consecutive LSU grants before fetch is forced a slot (only used with the optional feature).

Ports:
- i_fe_gck  in  1  clock.
- i_fe_rst_n  in  1  reset, asynchronous, active-low.
- o_fe_ctr  out  2 (ctr_t)  cycle-in-word counter, shared core-wide.
- i_fe_redirect  in  1  redirect PC this cycle.
- i_fe_redirect_pc  in  16  redirect target, word address.
- o_fe_enc  out  4 (slice_t)  instruction nibble to decode.
- o_fe_enc_vld  out  1  o_fe_enc valid.
- i_fe_lsu_req  in  1  LSU access request; held until granted.
- i_fe_lsu_wr  in  1  1 = write, 0 = read; stable while req.
- i_fe_lsu_addr  in  16  LSU word address; stable while req.
- o_fe_lsu_gnt  out  1  one-cycle grant pulse.
- i_fe_lsu_wdata  in  4  write nibble during data phase.
- o_fe_lsu_rdata  out  4  read nibble to LSU.
- o_fe_lsu_rvld  out  1  o_fe_lsu_rdata valid.
- o_fe_mem_req  out  1  address phase strobe.
- o_fe_mem_wr  out  1  write access.
- o_fe_mem_addr  out  16  word address.
- o_fe_mem_wdata  out  4  write nibble.
- i_fe_mem_rdata  in  4  read nibble, fixed latency.

Behaviour:
Timing frame
- Reset: ctr = 0, PC = RST_PC, slot owner = NONE. All outputs are 0 except o_fe_ctr = 0.
- ctr increments every cycle and wraps 3→0. A word slot is ctr 0..3.
- The address phase occurs only when ctr == 3: o_fe_mem_req = 1 with addr and wr valid that cycle only. It schedules the data phase for the next slot (ctr 0..3).
- Read data arrives on i_fe_mem_rdata during the data phase, LSB nibble first at ctr 0.
- Write data is driven on o_fe_mem_wdata during the data phase, passed through combinationally from i_fe_lsu_wdata. It is 0 otherwise.

Arbitration at ctr == 3
- If i_fe_lsu_req = 1: owner_next = LSU_RD or LSU_WR; o_fe_lsu_gnt = 1; addr = i_fe_lsu_addr.
- Otherwise: owner_next = FETCH; addr = PC (or i_fe_redirect_pc if a redirect is present this cycle); PC <= addr + 1, wrapping at 16'hFFFF → 0.
- Fetch issues every slot in which the LSU is not granted; there is no idle slot after reset.
- A redirect at ctr == 3 alongside an LSU grant: the LSU still wins, PC <= i_fe_redirect_pc, and no fetch is issued this slot.

Owner state machine
- States: NONE, FETCH, LSU_RD, LSU_WR, FETCH_SQUASH. Updated at the ctr 3→0 edge from owner_next.
- FETCH: o_fe_enc = i_fe_mem_rdata, o_fe_enc_vld = 1 for ctr 0..3.
- FETCH_SQUASH: o_fe_enc_vld = 0 and o_fe_enc = 0 for the rest of the slot.
- LSU_RD: o_fe_lsu_rdata = i_fe_mem_rdata, o_fe_lsu_rvld = 1, o_fe_enc_vld = 0.
- LSU_WR: o_fe_mem_wr was 1 at address phase; wdata passthrough; rvld = 0; enc_vld = 0.
- NONE (first slot after reset only): all valids 0.

Redirect
- i_fe_redirect at any ctr: PC <= i_fe_redirect_pc.
- If the owner is FETCH at ctr 0..2, it moves to FETCH_SQUASH the same cycle (enc_vld low that cycle and for the rest of the slot).
- A redirect at ctr == 3 squashes nothing, because the current slot is finished. The new fetch uses the target directly.
- Redirect has no effect on LSU slots.
- Back-to-back redirects: the last one wins.

Other rules
- Reset asserted mid-slot: everything returns to reset state at once and the next address phase is at ctr == 3.
- A new LSU request may be made the cycle after gnt; it is arbitrated at the next ctr == 3.

Optional Feature:
- Macro: IDLI_FETCH_ANTI_STARVE_EN.
- Defined:
  - A 3-bit counter counts consecutive LSU grants. It resets on reset and on any fetch grant.
  - When the count == STARVE_MAX at ctr == 3, fetch is granted even if i_fe_lsu_req = 1. The LSU stays pending, receives no gnt, and the count is cleared.
- Undefined: the LSU always has strict priority, the counter logic is absent, and STARVE_MAX is unused.

Test Plan:
- Reset, no LSU req, memory returns word 16'hA5C3 at addr 0: first mem_req at cycle 3, addr 0. During the next slot, enc = 3,C,5,A with enc_vld = 1. Second address phase uses addr 1.
- LSU read req addr 16'h0100 at ctr 1 with PC = 5: gnt pulse at ctr 3, mem_addr = 16'h0100, wr = 0. Next slot: lsu_rvld = 1 for 4 cycles, enc_vld = 0. The following address phase fetches addr 5 (PC unchanged).
- LSU write, wdata nibbles 1,2,3,4: mem_wr = 1 at address phase; o_fe_mem_wdata = 1,2,3,4 at ctr 0..3; no rvld; no enc_vld.
- Redirect to 16'h0040 at ctr 1 of a fetch slot: enc_vld = 0 at ctr 1..3. Next mem_addr = 16'h0040, then 16'h0041.
- PC = 16'hFFFF fetch: mem_addr = 16'hFFFF and the next fetch addr = 16'h0000. Redirect at ctr 3 to 16'h0200 simultaneous with an LSU req: LSU granted, and the next fetch is addr 16'h0200.
- With IDLI_FETCH_ANTI_STARVE_EN and LSU req held permanently: 4 LSU grants, then 1 fetch slot with no gnt, then LSU grants resume. Without the macro: gnt every slot and enc_vld never asserts.

Source files
------------

// File: rtl/idli_fetch_m.sv
// idli_fetch_m: instruction fetch sequencer and shared-memory scheduler.
// The block owns the PC and the free-running 2-bit cycle-in-word counter.
// It arbitrates the one-word-per-slot memory port between fetch and the LSU.
// Fetched words stream to decode one nibble per cycle.
// A redirect inside a fetch data phase squashes the rest of that fetch.
// Optional feature: define IDLI_FETCH_ANTI_STARVE_EN to force a fetch slot
// after STARVE_MAX consecutive LSU grants.
module idli_fetch_m #(
   parameter logic [15:0] RST_PC     = 16'h0000,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        i_fe_gck,
   input  logic        i_fe_rst_n,
   output logic [1:0]  o_fe_ctr,
   input  logic        i_fe_redirect,
   input  logic [15:0] i_fe_redirect_pc,
   output logic [3:0]  o_fe_enc,
   output logic        o_fe_enc_vld,
   input  logic        i_fe_lsu_req,
   input  logic        i_fe_lsu_wr,
   input  logic [15:0] i_fe_lsu_addr,
   output logic        o_fe_lsu_gnt,
   input  logic [3:0]  i_fe_lsu_wdata,
   output logic [3:0]  o_fe_lsu_rdata,
   output logic        o_fe_lsu_rvld,
   output logic        o_fe_mem_req,
   output logic        o_fe_mem_wr,
   output logic [15:0] o_fe_mem_addr,
   output logic [3:0]  o_fe_mem_wdata,
   input  logic [3:0]  i_fe_mem_rdata
);

   typedef logic [1:0] ctr_t;
   typedef logic [3:0] slice_t;

   typedef enum logic [2:0] {
      OWN_NONE,
      OWN_FETCH,
      OWN_LSU_RD,
      OWN_LSU_WR,
      OWN_FETCH_SQUASH
   } owner_t;

   ctr_t        ctr_q, ctr_d;
   logic [15:0] pc_q, pc_d;
   owner_t      owner_q, owner_d;

   logic        addr_ph;      // address phase of the next slot (ctr == 3)
   logic        force_fetch;  // anti-starvation override of the LSU
   logic        lsu_win;      // LSU owns the next slot
   logic        fetch_win;    // fetch owns the next slot
   logic [15:0] fetch_addr;   // redirect target bypasses the stale PC
   logic        squash_now;   // redirect during a data phase (ctr 0..2)

`ifdef IDLI_FETCH_ANTI_STARVE_EN
   localparam logic [2:0] STARVE_MAX_C = 3'(STARVE_MAX);

   logic [2:0] starve_q, starve_d;

   // Count consecutive LSU grants; a fetch grant restarts the run.
   always_comb begin
      starve_d = starve_q;
      if (fetch_win) begin
         starve_d = 3'd0;
      end else if (lsu_win) begin
         starve_d = starve_q + 3'd1;
      end
   end

   // Starvation counter register.
   always_ff @(posedge i_fe_gck or negedge i_fe_rst_n) begin
      if (!i_fe_rst_n) begin
         starve_q <= 3'd0;
      end else begin
         starve_q <= starve_d;
      end
   end

   assign force_fetch = (starve_q == STARVE_MAX_C);
`else
   // The LSU always has strict priority over fetch.
   assign force_fetch = 1'b0;
`endif

   // Slot arbitration and address selection.
   always_comb begin
      addr_ph    = (ctr_q == 2'd3);
      fetch_addr = i_fe_redirect ? i_fe_redirect_pc : pc_q;
      lsu_win    = addr_ph && i_fe_lsu_req && !force_fetch;
      fetch_win  = addr_ph && !lsu_win;
      squash_now = i_fe_redirect && !addr_ph;
   end

   // Next-state for counter, PC and slot owner.
   always_comb begin
      ctr_d   = ctr_q + 2'd1;
      pc_d    = pc_q;
      owner_d = owner_q;
      if (fetch_win) begin
         pc_d = fetch_addr + 16'd1;
      end else if (i_fe_redirect) begin
         pc_d = i_fe_redirect_pc;
      end
      if (addr_ph) begin
         if (lsu_win) begin
            owner_d = i_fe_lsu_wr ? OWN_LSU_WR : OWN_LSU_RD;
         end else begin
            owner_d = OWN_FETCH;
         end
      end else if (i_fe_redirect && (owner_q == OWN_FETCH)) begin
         owner_d = OWN_FETCH_SQUASH;
      end
   end

   // State registers.
   always_ff @(posedge i_fe_gck or negedge i_fe_rst_n) begin
      if (!i_fe_rst_n) begin
         ctr_q   <= 2'd0;
         pc_q    <= RST_PC;
         owner_q <= OWN_NONE;
      end else begin
         ctr_q   <= ctr_d;
         pc_q    <= pc_d;
         owner_q <= owner_d;
      end
   end

   // Memory port, decode and LSU outputs, decoded from the slot owner.
   always_comb begin
      o_fe_ctr       = ctr_q;
      o_fe_mem_req   = addr_ph;
      o_fe_mem_wr    = lsu_win && i_fe_lsu_wr;
      o_fe_mem_addr  = 16'h0000;
      o_fe_lsu_gnt   = lsu_win;
      o_fe_enc_vld   = 1'b0;
      o_fe_enc       = slice_t'(4'h0);
      o_fe_lsu_rvld  = 1'b0;
      o_fe_lsu_rdata = 4'h0;
      o_fe_mem_wdata = 4'h0;
      if (lsu_win) begin
         o_fe_mem_addr = i_fe_lsu_addr;
      end else if (fetch_win) begin
         o_fe_mem_addr = fetch_addr;
      end
      case (owner_q)
         OWN_FETCH: begin
            if (!squash_now) begin
               o_fe_enc_vld = 1'b1;
               o_fe_enc     = i_fe_mem_rdata;
            end
         end
         OWN_LSU_RD: begin
            o_fe_lsu_rvld  = 1'b1;
            o_fe_lsu_rdata = i_fe_mem_rdata;
         end
         OWN_LSU_WR: begin
            o_fe_mem_wdata = i_fe_lsu_wdata;
         end
         default: begin
         end
      endcase
   end

endmodule
